// File: rtl/flash_boot_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : flash_boot_loader_if
//  Description : Bundles the boot loader's control, flash-read and
//                instruction-memory write signals. The loader connects as
//                master; the surrounding MCU (or a bench) connects as slave.
//  Revision    : 1.0  initial release
// ============================================================================
interface flash_boot_loader_if #(
  parameter int PC_BITWIDTH = 16
);

  // control / status
  logic                   start;
  logic                   core_hold;
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [PC_BITWIDTH-2:0] words_written;

  // flash read port
  logic                   flash_read_req;
  logic [23:0]            flash_addr_read;
  logic                   flash_read_en_in;
  logic [7:0]             flash_byte_in;

  // instruction-memory write port
  logic                   inst_mem_we;
  logic [PC_BITWIDTH-3:0] inst_mem_wr_addr;
  logic [31:0]            inst_mem_data_in;

  modport master (
    input  start,
    input  flash_read_en_in,
    input  flash_byte_in,
    output flash_read_req,
    output flash_addr_read,
    output inst_mem_we,
    output inst_mem_wr_addr,
    output inst_mem_data_in,
    output core_hold,
    output busy,
    output done,
    output error,
    output words_written
  );

  modport slave (
    output start,
    output flash_read_en_in,
    output flash_byte_in,
    input  flash_read_req,
    input  flash_addr_read,
    input  inst_mem_we,
    input  inst_mem_wr_addr,
    input  inst_mem_data_in,
    input  core_hold,
    input  busy,
    input  done,
    input  error,
    input  words_written
  );

endinterface
`default_nettype wire

// File: rtl/flash_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : flash_boot_loader
//  Description : Copies a length-prefixed image (2-byte little-endian byte
//                count followed by the payload) from serial flash into the
//                core's instruction memory as little-endian 32-bit words,
//                holding the core in reset until the copy completes.
//                One flash request is outstanding at a time; every wait for
//                a flash byte is bounded by TIMEOUT_CYCLES.
//  Revision    : 1.0  initial release
// ============================================================================
module flash_boot_loader #(
  parameter int          PC_BITWIDTH     = 16,
  parameter logic [23:0] FLASH_BASE_ADDR = 24'h000000,
  parameter int          TIMEOUT_CYCLES  = 1024   // must be >= 2
) (
  input  wire logic           clk,
  input  wire logic           reset,
  flash_boot_loader_if.master bus
);

  localparam int WA_W  = PC_BITWIDTH - 2;             // word address width
  localparam int WW_W  = PC_BITWIDTH - 1;             // word counter width
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  // The request cycle itself counts as the first elapsed cycle, so the last
  // wait cycle sees the counter at TIMEOUT_CYCLES-2.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

  // Largest image that fits in instruction memory, in bytes.
  localparam logic [31:0] MAX_LEN = 32'd1 << PC_BITWIDTH;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ_LEN   = 3'd1,
    S_WAIT_LEN  = 3'd2,
    S_REQ_DATA  = 3'd3,
    S_WAIT_DATA = 3'd4,
    S_WRITE     = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  state_t           state_q;

  // registered outputs
  logic             req_q;
  logic [23:0]      addr_q;
  logic             we_q;
  logic [WA_W-1:0]  wr_addr_q;
  logic [31:0]      data_q;
  logic             hold_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic [WW_W-1:0]  ww_q;

  // internal state
  logic [TMO_W-1:0] tmo_q;      // cycles elapsed since the last request
  logic             hdr_hi_q;   // next header byte is the high length byte
  logic [7:0]       len_lo_q;   // low length byte, held until the high one
  logic [15:0]      len_q;      // image length L in bytes
  logic [15:0]      cnt_q;      // payload bytes consumed so far
  logic [31:0]      word_q;     // word under assembly, unused bytes zero
  logic             last_q;     // the pending write carries the final byte

  // next-value helpers
  logic [23:0]      addr_d;
  logic [15:0]      cnt_d;
  logic [15:0]      len_d;
  logic [31:0]      word_d;
  logic             oversize_d;
  logic             last_byte_d;
  logic             word_full_d;
  logic             tmo_exp_d;

  // Incoming-byte arithmetic: address step, word merge and length checks.
  always_comb begin
    addr_d      = addr_q + 24'd1;         // wraps FFFFFF -> 000000
    cnt_d       = cnt_q + 16'd1;
    len_d       = {bus.flash_byte_in, len_lo_q};
    oversize_d  = ({16'd0, len_d} > MAX_LEN);
    last_byte_d = (cnt_d == len_q);
    word_full_d = (cnt_q[1:0] == 2'd3);
    tmo_exp_d   = (tmo_q == TMO_LAST);
    word_d      = word_q;
    case (cnt_q[1:0])
      2'd0:    word_d[7:0]   = bus.flash_byte_in;
      2'd1:    word_d[15:8]  = bus.flash_byte_in;
      2'd2:    word_d[23:16] = bus.flash_byte_in;
      default: word_d[31:24] = bus.flash_byte_in;
    endcase
  end

  // Load sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      addr_q    <= FLASH_BASE_ADDR;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      data_q    <= '0;
      hold_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      ww_q      <= '0;
      tmo_q     <= '0;
      hdr_hi_q  <= 1'b0;
      len_lo_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      case (state_q)
        // Resting states: only here is start honoured.
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            ww_q     <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            hdr_hi_q <= 1'b0;
            busy_q   <= 1'b1;
            hold_q   <= 1'b1;
            addr_q   <= FLASH_BASE_ADDR;
            req_q    <= 1'b1;
            state_q  <= S_REQ_LEN;
          end
        end

        S_REQ_LEN: begin
          req_q   <= 1'b0;
          tmo_q   <= '0;
          state_q <= S_WAIT_LEN;
        end

        S_WAIT_LEN: begin
          if (bus.flash_read_en_in) begin
            addr_q <= addr_d;
            if (!hdr_hi_q) begin
              len_lo_q <= bus.flash_byte_in;
              hdr_hi_q <= 1'b1;
              req_q    <= 1'b1;
              state_q  <= S_REQ_LEN;
            end else begin
              len_q <= len_d;
              if (len_d == 16'd0) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                hold_q  <= 1'b0;
                state_q <= S_DONE;
              end else if (oversize_d) begin
                busy_q  <= 1'b0;
                error_q <= 1'b1;
                state_q <= S_ERROR;
              end else begin
                req_q   <= 1'b1;
                state_q <= S_REQ_DATA;
              end
            end
          end else if (tmo_exp_d) begin
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        S_REQ_DATA: begin
          req_q   <= 1'b0;
          tmo_q   <= '0;
          state_q <= S_WAIT_DATA;
        end

        S_WAIT_DATA: begin
          if (bus.flash_read_en_in) begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            if (word_full_d || last_byte_d) begin
              // word_q only ever holds bytes of the current word, so a
              // short final word leaves its upper bytes zero.
              we_q      <= 1'b1;
              data_q    <= word_d;
              wr_addr_q <= ww_q[WA_W-1:0];
              ww_q      <= ww_q + WW_W'(1);
              last_q    <= last_byte_d;
              word_q    <= '0;
              state_q   <= S_WRITE;
            end else begin
              word_q  <= word_d;
              req_q   <= 1'b1;
              state_q <= S_REQ_DATA;
            end
          end else if (tmo_exp_d) begin
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            state_q <= S_ERROR;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        S_WRITE: begin
          we_q <= 1'b0;
          if (last_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hold_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            req_q   <= 1'b1;
            state_q <= S_REQ_DATA;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.flash_read_req   = req_q;
  assign bus.flash_addr_read  = addr_q;
  assign bus.inst_mem_we      = we_q;
  assign bus.inst_mem_wr_addr = wr_addr_q;
  assign bus.inst_mem_data_in = data_q;
  assign bus.core_hold        = hold_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.error            = error_q;
  assign bus.words_written    = ww_q;

endmodule
`default_nettype wire

// File: tb/tb_flash_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_flash_boot_loader
//  Description : Directed self-checking bench for flash_boot_loader with a
//                behavioural flash responder and an instruction-memory
//                capture model. Image base sits at FFFFFE so every load
//                also crosses the 24-bit address wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_flash_boot_loader;

  localparam int          PCW  = 8;
  localparam logic [23:0] BASE = 24'hFFFFFE;
  localparam int          TMO  = 16;

  logic clk;
  logic reset;

  flash_boot_loader_if #(.PC_BITWIDTH(PCW)) ifc ();

  flash_boot_loader #(
    .PC_BITWIDTH    (PCW),
    .FLASH_BASE_ADDR(BASE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          n_req  = 0;
  int          req_cyc = 0;
  int          n_wr   = 0;
  int          answer_max = 1000;
  int          resp_delay = 3;
  int          seq = 0;
  int          req_base;
  int          err_cyc;
  logic [7:0]  flash_mem [0:511];
  logic [31:0] mem_model [0:63];
  logic        hold_ok = 1'b1;
  logic        clr_mon = 1'b0;
  logic        spur_mode = 1'b0;
  logic        idle_spur = 1'b0;
  logic        r_en = 1'b0;
  logic        inj_en = 1'b0;
  logic [7:0]  r_byte = 8'h00;
  logic [23:0] cap_addr;
  logic [23:0] off;

  assign ifc.flash_read_en_in = r_en | inj_en;
  assign ifc.flash_byte_in    = r_en ? r_byte : 8'hEE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flash model: answers each request resp_delay cycles later with one
  // strobe, unless the request is beyond answer_max within the current load.
  initial begin
    #1;
    wait (reset === 1'b0);
    forever begin
      if (ifc.flash_read_req !== 1'b1) begin
        @(posedge clk); #1;
      end else begin
        n_req++;
        req_cyc  = cyc;
        cap_addr = ifc.flash_addr_read;
        seq      = (cap_addr == BASE) ? 0 : seq + 1;
        if (seq < answer_max) begin
          repeat (resp_delay) @(posedge clk);
          #1;
          if (ifc.busy === 1'b1) check("addr_stable", ifc.flash_addr_read, cap_addr);
          off    = cap_addr - BASE;
          r_byte = flash_mem[off[8:0]];
          r_en   = 1'b1;
          @(posedge clk); #1;
          r_en   = 1'b0;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
  end

  // Spurious strobes: during WRITE cycles when enabled, and on demand.
  initial begin
    forever begin
      @(posedge clk); #2;
      inj_en = (spur_mode && (ifc.inst_mem_we === 1'b1)) || idle_spur;
    end
  end

  // Instruction-memory capture.
  always @(negedge clk) begin
    if (clr_mon) begin
      for (int i = 0; i < 64; i++) mem_model[i] <= 32'hDEADBEEF;
      n_wr    <= 0;
      hold_ok <= 1'b1;
    end else if (ifc.inst_mem_we === 1'b1) begin
      mem_model[ifc.inst_mem_wr_addr] <= ifc.inst_mem_data_in;
      n_wr <= n_wr + 1;
      if (ifc.core_hold !== 1'b1) hold_ok <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic start_load();
    @(posedge clk); #1;
    clr_mon   = 1'b1;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    clr_mon   = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int bound);
    int n = 0;
    while (!(ifc.done === 1'b1 || ifc.error === 1'b1) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(ifc.done === 1'b1 || ifc.error === 1'b1), 32'd1);
  endtask

  task automatic check_reset_values(input string p);
    check({p, "_req"},   32'(ifc.flash_read_req),   32'd0);
    check({p, "_addr"},  32'(ifc.flash_addr_read),  32'(BASE));
    check({p, "_we"},    32'(ifc.inst_mem_we),      32'd0);
    check({p, "_wa"},    32'(ifc.inst_mem_wr_addr), 32'd0);
    check({p, "_wd"},    ifc.inst_mem_data_in,      32'd0);
    check({p, "_hold"},  32'(ifc.core_hold),        32'd1);
    check({p, "_busy"},  32'(ifc.busy),             32'd0);
    check({p, "_done"},  32'(ifc.done),             32'd0);
    check({p, "_err"},   32'(ifc.error),            32'd0);
    check({p, "_ww"},    32'(ifc.words_written),    32'd0);
  endtask

  task automatic load_basic_image();
    flash_mem[0] = 8'h08; flash_mem[1] = 8'h00;
    flash_mem[2] = 8'h11; flash_mem[3] = 8'h22; flash_mem[4] = 8'h33;
    flash_mem[5] = 8'h44; flash_mem[6] = 8'h55; flash_mem[7] = 8'h66;
    flash_mem[8] = 8'h77; flash_mem[9] = 8'h88;
  endtask

  initial begin
    reset     = 1'b1;
    ifc.start = 1'b0;
    for (int i = 0; i < 512; i++) flash_mem[i] = 8'(i) ^ 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;

    // ---- basic 8-byte image, 3-cycle flash latency
    load_basic_image();
    resp_delay = 3;
    req_base   = n_req;
    start_load();
    check("s1_busy", 32'(ifc.busy), 32'd1);
    wait_end("s1_end", 400);
    check("s1_done", 32'(ifc.done), 32'd1);
    check("s1_err",  32'(ifc.error), 32'd0);
    check("s1_hold", 32'(ifc.core_hold), 32'd0);
    check("s1_hold_at_wr", 32'(hold_ok), 32'd1);
    check("s1_ww",   32'(ifc.words_written), 32'd2);
    check("s1_m0",   mem_model[0], 32'h44332211);
    check("s1_m1",   mem_model[1], 32'h88776655);
    check("s1_nwr",  32'(n_wr), 32'd2);
    check("s1_nreq", 32'(n_req - req_base), 32'd10);

    // ---- 5-byte image: zero-padded final word
    flash_mem[0] = 8'h05; flash_mem[1] = 8'h00;
    flash_mem[2] = 8'hAA; flash_mem[3] = 8'hBB; flash_mem[4] = 8'hCC;
    flash_mem[5] = 8'hDD; flash_mem[6] = 8'hEE;
    req_base = n_req;
    start_load();
    check("s2_done_clr", 32'(ifc.done), 32'd0);
    wait_end("s2_end", 400);
    check("s2_done", 32'(ifc.done), 32'd1);
    check("s2_m0",   mem_model[0], 32'hDDCCBBAA);
    check("s2_m1",   mem_model[1], 32'h000000EE);
    check("s2_ww",   32'(ifc.words_written), 32'd2);
    check("s2_nreq", 32'(n_req - req_base), 32'd7);

    // ---- zero-length image
    flash_mem[0] = 8'h00; flash_mem[1] = 8'h00;
    req_base = n_req;
    start_load();
    wait_end("s3_end", 200);
    check("s3_done", 32'(ifc.done), 32'd1);
    check("s3_nwr",  32'(n_wr), 32'd0);
    check("s3_ww",   32'(ifc.words_written), 32'd0);
    check("s3_nreq", 32'(n_req - req_base), 32'd2);

    // ---- oversize image: 257 bytes into a 256-byte memory
    flash_mem[0] = 8'h01; flash_mem[1] = 8'h01;
    req_base = n_req;
    start_load();
    wait_end("s4_end", 200);
    check("s4_err",  32'(ifc.error), 32'd1);
    check("s4_done", 32'(ifc.done), 32'd0);
    check("s4_hold", 32'(ifc.core_hold), 32'd1);
    check("s4_nwr",  32'(n_wr), 32'd0);
    check("s4_nreq", 32'(n_req - req_base), 32'd2);

    // ---- exactly full memory: 256 bytes, 1-cycle flash latency
    for (int i = 0; i < 512; i++) flash_mem[i] = 8'(i) ^ 8'h5A;
    flash_mem[0] = 8'h00; flash_mem[1] = 8'h01;
    resp_delay = 1;
    start_load();
    check("s5_err_clr", 32'(ifc.error), 32'd0);
    wait_end("s5_end", 2000);
    check("s5_done", 32'(ifc.done), 32'd1);
    check("s5_ww",   32'(ifc.words_written), 32'd64);
    check("s5_m0",   mem_model[0],  32'h5F5E5958);
    check("s5_m63",  mem_model[63], 32'h5B5AA5A4);
    check("s5_nwr",  32'(n_wr), 32'd64);

    // ---- flash never answers the first data request
    load_basic_image();
    resp_delay = 3;
    answer_max = 2;
    req_base   = n_req;
    start_load();
    begin
      int n = 0;
      while (ifc.error !== 1'b1 && n < 200) begin
        @(posedge clk); #1;
        n++;
      end
      err_cyc = cyc;
    end
    check("s6_err",     32'(ifc.error), 32'd1);
    check("s6_latency", 32'(err_cyc - req_cyc), 32'(TMO));
    check("s6_hold",    32'(ifc.core_hold), 32'd1);
    check("s6_busy",    32'(ifc.busy), 32'd0);
    repeat (20) @(posedge clk);
    #1;
    check("s6_nreq", 32'(n_req - req_base), 32'd3);
    check("s6_nwr",  32'(n_wr), 32'd0);
    answer_max = 1000;

    // ---- spurious strobes in idle and WRITE, start while busy
    req_base  = n_req;
    idle_spur = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    idle_spur = 1'b0;
    check("s7_idle_busy", 32'(ifc.busy), 32'd0);
    check("s7_idle_nreq", 32'(n_req - req_base), 32'd0);
    spur_mode = 1'b1;
    start_load();
    repeat (12) @(posedge clk);
    #1;
    ifc.start = 1'b1;
    @(posedge clk); #1;
    ifc.start = 1'b0;
    wait_end("s7_end", 400);
    spur_mode = 1'b0;
    check("s7_done", 32'(ifc.done), 32'd1);
    check("s7_m0",   mem_model[0], 32'h44332211);
    check("s7_m1",   mem_model[1], 32'h88776655);
    check("s7_ww",   32'(ifc.words_written), 32'd2);
    check("s7_nwr",  32'(n_wr), 32'd2);
    check("s7_nreq", 32'(n_req - req_base), 32'd10);

    // ---- reset between the 6th and 7th byte, then reload
    req_base = n_req;
    start_load();
    begin
      int n = 0;
      while ((n_req - req_base) < 7 && n < 200) begin
        @(posedge clk); #2;
        n++;
      end
    end
    check("s8_reached", 32'(n_req - req_base), 32'd7);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("s8_rst");
    reset = 1'b0;
    check("s8_nwr", 32'(n_wr), 32'd1);
    check("s8_m0",  mem_model[0], 32'h44332211);
    repeat (6) @(posedge clk);
    start_load();
    wait_end("s8_end", 400);
    check("s8_done", 32'(ifc.done), 32'd1);
    check("s8_m0b",  mem_model[0], 32'h44332211);
    check("s8_m1b",  mem_model[1], 32'h88776655);
    check("s8_ww",   32'(ifc.words_written), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
